// File: rtl/rr_packet_allocator.sv
// Round-robin allocator for one switch output: grants a header in the same cycle and
// holds the output for that packet until tail, protocol error or idle timeout.
module rr_packet_allocator #(
  parameter int PORTS   = 4,
  parameter int ADR_W   = $clog2(PORTS),
  parameter int TIMEOUT = 16
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [ADR_W-1:0]                r_adr,
  input  logic [PORTS-1:0][ADR_W+1:0]     in_ch_hdr_msn,
  input  logic                            out_ready,
  output logic [PORTS-1:0]                sel,
  output logic                            shift,
  output logic                            busy,
  output logic [ADR_W-1:0]                owner,
  output logic                            timeout_err,
  output logic                            proto_err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  localparam logic [1:0] FT_NULL    = 2'b00;
  localparam logic [1:0] FT_TAIL    = 2'b01;
  localparam logic [1:0] FT_PAYLOAD = 2'b10;
  localparam logic [1:0] FT_HEADER  = 2'b11;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t            state_reg;
  logic [ADR_W-1:0]  ptr_reg;
  logic [ADR_W-1:0]  owner_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic              timeout_err_reg;
  logic              proto_err_reg;

  logic [1:0]        ftype [PORTS];
  logic [PORTS-1:0]  req;

  generate
    for (genvar gi = 0; gi < PORTS; gi++) begin : g_decode
      assign ftype[gi] = in_ch_hdr_msn[gi][ADR_W+1:ADR_W];
      assign req[gi]   = (in_ch_hdr_msn[gi][ADR_W+1:ADR_W] == FT_HEADER) &&
                         (in_ch_hdr_msn[gi][ADR_W-1:0] == r_adr);
    end
  endgenerate

  // Rotating search starting at ptr; the first requester found wins.
  logic              grant_any;
  logic [ADR_W-1:0]  grant_idx;
  logic [ADR_W-1:0]  grant_next_ptr;

  always_comb begin
    int idx;
    grant_any = 1'b0;
    grant_idx = '0;
    idx       = 0;
    for (int k = 0; k < PORTS; k++) begin
      idx = int'(ptr_reg) + k;
      if (idx >= PORTS) idx = idx - PORTS;
      if (!grant_any && req[idx]) begin
        grant_any = 1'b1;
        grant_idx = ADR_W'(idx);
      end
    end
    if (int'(grant_idx) == PORTS - 1) grant_next_ptr = '0;
    else                              grant_next_ptr = grant_idx + 1'b1;
  end

  logic [1:0] owner_type;

  always_comb begin
    owner_type = FT_NULL;
    for (int k = 0; k < PORTS; k++) begin
      if (ADR_W'(k) == owner_reg) owner_type = ftype[k];
    end
  end

  // The mux select and transfer strobe are combinational so a header moves with zero latency.
  always_comb begin
    sel   = '0;
    shift = 1'b0;
    if (rst_n) begin
      if (state_reg == IDLE) begin
        if (grant_any && out_ready) begin
          for (int k = 0; k < PORTS; k++) begin
            if (ADR_W'(k) == grant_idx) sel[k] = 1'b1;
          end
          shift = 1'b1;
        end
      end else begin
        for (int k = 0; k < PORTS; k++) begin
          if (ADR_W'(k) == owner_reg) sel[k] = 1'b1;
        end
        shift = out_ready && ((owner_type == FT_PAYLOAD) || (owner_type == FT_TAIL));
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      ptr_reg         <= '0;
      owner_reg       <= '0;
      cnt_reg         <= '0;
      timeout_err_reg <= 1'b0;
      proto_err_reg   <= 1'b0;
    end else begin
      timeout_err_reg <= 1'b0;
      proto_err_reg   <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (grant_any && out_ready) begin
            state_reg <= HOLD;
            owner_reg <= grant_idx;
            ptr_reg   <= grant_next_ptr;
            cnt_reg   <= '0;
          end
        end
        HOLD: begin
          case (owner_type)
            FT_PAYLOAD: begin
              if (out_ready) cnt_reg <= '0;
            end
            FT_TAIL: begin
              if (out_ready) state_reg <= IDLE;
            end
            FT_NULL: begin
              // Only idle flits from the owner age the packet; backpressure never does.
              if (cnt_reg == CNT_LAST) begin
                state_reg       <= IDLE;
                timeout_err_reg <= 1'b1;
              end else if (cnt_reg != CNT_MAX) begin
                cnt_reg <= cnt_reg + 1'b1;
              end
            end
            default: begin
              state_reg     <= IDLE;
              proto_err_reg <= 1'b1;
            end
          endcase
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign busy        = rst_n && (state_reg == HOLD);
  assign owner       = owner_reg;
  assign timeout_err = timeout_err_reg;
  assign proto_err   = proto_err_reg;

endmodule

// File: tb/tb_rr_packet_allocator.sv
// Directed bench for rr_packet_allocator: a packet-level reference model checked every
// cycle, plus literal expectations for grant order, hold, backpressure, timeout and reset.
module tb_rr_packet_allocator;

  localparam int PORTS   = 4;
  localparam int ADR_W   = 2;
  localparam int TIMEOUT = 4;

  localparam logic [3:0] H2 = 4'b1110;  // header for dest 2
  localparam logic [3:0] H0 = 4'b1100;  // header for dest 0
  localparam logic [3:0] PL = 4'b1000;
  localparam logic [3:0] TL = 4'b0100;
  localparam logic [3:0] NL = 4'b0000;

  logic                        clk = 1'b0;
  logic                        rst_n = 1'b0;
  logic [ADR_W-1:0]            r_adr = 2'd2;
  logic [PORTS-1:0][ADR_W+1:0] flits = '0;
  logic                        out_ready = 1'b1;
  logic [PORTS-1:0]            sel;
  logic                        shift;
  logic                        busy;
  logic [ADR_W-1:0]            owner;
  logic                        timeout_err;
  logic                        proto_err;

  rr_packet_allocator #(.PORTS(PORTS), .ADR_W(ADR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .r_adr(r_adr), .in_ch_hdr_msn(flits),
    .out_ready(out_ready), .sel(sel), .shift(shift), .busy(busy),
    .owner(owner), .timeout_err(timeout_err), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Packet-level model: is a packet open, who owns it, where the rotation starts, idle age.
  bit m_hold;
  int m_owner, m_ptr, m_idle;
  bit m_terr, m_perr;
  int grants[$];

  int last_sel, last_shift, last_busy, last_terr, last_perr;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%0d required=%0d", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_hold = 0; m_owner = 0; m_ptr = 0; m_idle = 0; m_terr = 0; m_perr = 0;
  endtask

  function automatic int winner(input logic [PORTS-1:0][ADR_W+1:0] f);
    for (int k = 0; k < PORTS; k++) begin
      int idx;
      idx = (m_ptr + k) % PORTS;
      if (f[idx][3:2] == 2'b11 && f[idx][1:0] == r_adr) return idx;
    end
    return -1;
  endfunction

  // Drive one cycle at posedge+1, check mid-cycle, advance the model after the edge.
  task automatic step(input logic [PORTS-1:0][ADR_W+1:0] f, input logic rdy);
    int g, t, exp_sel, exp_shift;
    bit was_hold;
    g = -1; t = 0; exp_sel = 0; exp_shift = 0;
    was_hold = m_hold;
    flits = f;
    out_ready = rdy;
    #2;
    if (!was_hold) begin
      g = winner(f);
      if (g >= 0 && rdy) begin
        exp_sel = 1 << g;
        exp_shift = 1;
      end
    end else begin
      t = int'(f[m_owner][3:2]);
      exp_sel = 1 << m_owner;
      exp_shift = (rdy && (t == 2 || t == 1)) ? 1 : 0;
    end
    last_sel = int'(sel); last_shift = int'(shift); last_busy = int'(busy);
    last_terr = int'(timeout_err); last_perr = int'(proto_err);
    chk("sel", last_sel, exp_sel);
    chk("shift", last_shift, exp_shift);
    chk("busy", last_busy, int'(m_hold));
    chk("timeout_err", last_terr, int'(m_terr));
    chk("proto_err", last_perr, int'(m_perr));
    if (m_hold) chk("owner", int'(owner), m_owner);
    chk("inv_onehot0", int'($onehot0(sel)), 1);
    chk("inv_shift_sel", int'(shift && sel == '0), 0);
    chk("inv_shift_rdy", int'(shift && !out_ready), 0);
    $display("cyc=%0d flits=%h rdy=%0d sel=%b shift=%0d busy=%0d owner=%0d terr=%0d perr=%0d",
             cyc, f, rdy, sel, shift, busy, owner, timeout_err, proto_err);
    @(posedge clk);
    #1;
    cyc++;
    m_terr = 0;
    m_perr = 0;
    if (!was_hold) begin
      if (g >= 0 && rdy) begin
        grants.push_back(g);
        m_hold = 1; m_owner = g; m_ptr = (g + 1) % PORTS; m_idle = 0;
      end
    end else begin
      case (t)
        2: if (rdy) m_idle = 0;
        1: if (rdy) m_hold = 0;
        0: if (m_idle == TIMEOUT - 1) begin m_hold = 0; m_terr = 1; end
           else m_idle++;
        default: begin m_hold = 0; m_perr = 1; end
      endcase
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cycle=%0d actual=running required=finished", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [PORTS-1:0][ADR_W+1:0] f;
    int exp_rr[5];
    int hold_cnt, bp_shift, bp_terr;
    exp_rr = '{0, 1, 2, 3, 0};

    // Reset: outputs forced low even with requests present.
    model_reset();
    flits = {H2, H2, H2, H2};
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("rst_sel", int'(sel), 0);
    chk("rst_shift", int'(shift), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_owner", int'(owner), 0);
    chk("rst_terr", int'(timeout_err), 0);
    chk("rst_perr", int'(proto_err), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Round robin: everyone requests, each winner sends a tail next cycle.
    for (int r = 0; r < 5; r++) begin
      f = {H2, H2, H2, H2};
      step(f, 1'b1);
      f[m_owner] = TL;
      step(f, 1'b1);
    end
    for (int k = 0; k < 5; k++) chk($sformatf("rr_order_%0d", k), grants[k], exp_rr[k]);

    // Hold: ch1 owns for header+3 payload+tail while ch0 waits.
    grants.delete();
    hold_cnt = 0;
    f = {NL, NL, H2, H2};
    step(f, 1'b1);
    if (last_sel == 2 && last_shift == 1) hold_cnt++;
    for (int k = 0; k < 4; k++) begin
      f[1] = (k == 3) ? TL : PL;
      step(f, 1'b1);
      if (last_sel == 2 && last_shift == 1) hold_cnt++;
    end
    f = {NL, NL, NL, H2};
    step(f, 1'b1);
    chk("hold_ch0_after", last_sel, 1);
    f[0] = TL;
    step(f, 1'b1);
    chk("hold_cycles", hold_cnt, 5);
    chk("hold_ngrants", grants.size(), 2);
    chk("hold_first", grants[0], 1);

    // Backpressure mid-packet on ch2.
    bp_shift = 0; bp_terr = 0;
    f = {NL, H2, NL, NL};
    step(f, 1'b1);
    chk("bp_grant", last_sel, 4);
    f[2] = PL;
    step(f, 1'b1);
    for (int k = 0; k < 3; k++) begin
      step(f, 1'b0);
      bp_shift += last_shift;
      if (last_sel != 4) bp_shift += 100;
    end
    step(f, 1'b1);
    f[2] = TL;
    step(f, 1'b1);
    bp_terr += last_terr;
    f = {NL, NL, NL, NL};
    step(f, 1'b1);
    bp_terr += last_terr;
    chk("bp_noshift", bp_shift, 0);
    chk("bp_noterr", bp_terr, 0);

    // Timeout: ch3 goes silent for TIMEOUT cycles while ch1 waits.
    f = {H2, NL, NL, NL};
    step(f, 1'b1);
    chk("to_grant3", last_sel, 8);
    f = {NL, NL, H2, NL};
    for (int k = 0; k < TIMEOUT; k++) step(f, 1'b1);
    step(f, 1'b1);
    chk("to_err", last_terr, 1);
    chk("to_busy", last_busy, 0);
    chk("to_next_grant", last_sel, 2);
    f[1] = TL;
    step(f, 1'b1);
    chk("to_err_pulse", last_terr, 0);

    // Filtering and protocol error.
    f = {NL, NL, NL, H0};
    step(f, 1'b1);
    chk("filt_sel", last_sel, 0);
    chk("filt_shift", last_shift, 0);
    f[0] = H2;
    step(f, 1'b1);
    chk("perr_grant", last_sel, 1);
    f[0] = PL;
    step(f, 1'b1);
    f[0] = H2;
    step(f, 1'b1);
    chk("perr_noshift", last_shift, 0);
    step(f, 1'b1);
    chk("perr_pulse", last_perr, 1);
    chk("perr_idle", last_busy, 0);
    chk("perr_regrant", last_sel * 2 + last_shift, 3);

    // Asynchronous reset while ch0 holds.
    flits = {NL, NL, NL, PL};
    out_ready = 1'b1;
    #2;
    chk("arst_pre_sel", int'(sel), 1);
    rst_n = 1'b0;
    #1;
    chk("arst_sel", int'(sel), 0);
    chk("arst_shift", int'(shift), 0);
    chk("arst_busy", int'(busy), 0);
    model_reset();
    @(posedge clk); #1;
    cyc++;
    rst_n = 1'b1;
    f = {H2, H2, H2, H2};
    step(f, 1'b1);
    chk("arst_tie_ch0", last_sel, 1);
    f[0] = TL;
    step(f, 1'b1);

    // Mixed traffic for a different output address, checked by the model alone.
    r_adr = 2'd1;
    for (int n = 0; n < 300; n++) begin
      for (int p = 0; p < PORTS; p++) f[p] = 4'($urandom_range(0, 15));
      step(f, ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0);
    end
    f = '0;
    for (int n = 0; n < 40; n++) begin
      f[0] = (n % 8 == 0) ? 4'b1101 : NL;
      step(f, 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rr_packet_allocator.md
Name: rr_packet_allocator

Overview:
- Output-port allocator for one output channel of the butterfly switch.
- Arbitrates among PORTS input channels whose header flits target this output (dest == r_adr), using a rotating round-robin priority.
- Holds the output for the winner until an explicit tail flit.
- Adds downstream backpressure and a stalled-packet timeout, which fixed-priority arbitration with implicit payload hold lacks.

Parameters:
- PORTS, 4, number of input channels; any value >= 2.
- ADR_W, $clog2(PORTS), width of the destination/router address field.
- TIMEOUT, 16, consecutive idle (NULL-flit) cycles tolerated while holding before forced release; >= 1.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- r_adr  in  ADR_W  address of the output port this allocator serves.
- in_ch_hdr_msn  in  PORTS x (2+ADR_W)  per-channel flit control: [ADR_W+1:ADR_W] type, [ADR_W-1:0] dest.
- out_ready  in  1  downstream can accept a flit this cycle.
- sel  out  PORTS  one-hot (or zero) mux select to the output.
- shift  out  1  a flit is transferred this cycle.
- busy  out  1  registered; output held by a packet.
- owner  out  ADR_W  registered index of the holding channel; valid when busy.
- timeout_err  out  1  one-cycle registered pulse on forced release.
- proto_err  out  1  one-cycle registered pulse on header-during-hold.

Behaviour:
- Flit types: 2'b11 HEADER, 2'b10 PAYLOAD, 2'b01 TAIL, 2'b00 NULL.
- req[i] = (type == HEADER) && (dest == r_adr).
- Reset (async assert, sync-released use):
  - state IDLE, ptr 0, owner 0, idle counter 0.
  - busy, timeout_err and proto_err are 0.
  - sel and shift are combinational and evaluate to 0 in IDLE with no request; during reset they are forced to 0.
- IDLE:
  - If |req && out_ready: winner g = first requester searching ptr, ptr+1, … mod PORTS.
  - Same cycle: sel = onehot(g), shift = 1 (header transferred, zero-latency grant).
  - Next edge: state HOLD, owner <= g, ptr <= (g+1) mod PORTS, counter <= 0.
  - If out_ready = 0 or no req: sel = 0, shift = 0, ptr unchanged.
- HOLD:
  - sel = onehot(owner) every cycle; requests from other channels are ignored.
  - PAYLOAD on owner with out_ready: shift = 1; counter <= 0.
  - TAIL on owner with out_ready: shift = 1; next state IDLE. Headers on other channels may be granted the following cycle, not the tail cycle.
  - PAYLOAD/TAIL with out_ready = 0: shift = 0; state and counter unchanged. Backpressure never counts toward timeout.
  - NULL on owner: shift = 0; counter increments. When counter reaches TIMEOUT - 1 on a NULL cycle, next state IDLE and timeout_err pulses on the next cycle.
  - HEADER on owner: no shift; next state IDLE; proto_err pulses. The header re-arbitrates from IDLE normally.
- Counter width: $clog2(TIMEOUT+1); saturates, never wraps.
- Invariants (assert in bench):
  - $onehot0(sel) always.
  - shift implies |sel.
  - shift implies out_ready.
  - busy == (state == HOLD).
- Reset asserted mid-packet: immediate return to IDLE; sel, shift and busy drop asynchronously. Partial packets are not resumed.

Test Plan:
- Round-robin (PORTS = 4, r_adr = 2): all 4 channels repeatedly send HEADER(dest 2) then TAIL → grant order 0, 1, 2, 3, 0; each grant followed by 1 hold cycle; ptr wraps 3→0.
- Hold: ch1 sends HEADER, PAYLOAD x3, TAIL while ch0 HEADER waits → sel = 4'b0010 for 5 cycles with shift = 1; ch0 granted the cycle after IDLE re-entry.
- Backpressure: out_ready = 0 for 3 cycles mid-packet → sel held at owner, shift = 0, counter unchanged; packet completes after out_ready returns, no timeout_err.
- Timeout (TIMEOUT = 4): owner sends 4 consecutive NULL flits → timeout_err = 1 for one cycle, busy = 0; a waiting header is granted next.
- Filtering/protocol: HEADER with dest != r_adr → no grant. Owner emits HEADER mid-packet → proto_err pulse, return to IDLE, header re-granted.
- Async reset: rst_n low during HOLD → sel = 0, shift = 0, busy = 0 without a clock edge; after release, ptr = 0 and ch0 wins ties.
